// File: rtl/onehot_encoder_8_3.sv
// Serialises each accepted 8-bit request vector into one 3-bit index per set bit,
// lowest-first (ORDER=0) or highest-first (ORDER=1), with valid/ready on both sides.
module onehot_encoder_8_3 #(
    parameter int unsigned ORDER = 0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    input  logic [7:0] in_bits,
    output logic       in_ready,
    output logic       out_valid,
    output logic [2:0] out_idx,
    output logic       out_last,
    input  logic       out_ready,
    output logic       zero_drop
);

    localparam int unsigned W  = 8;
    localparam int unsigned IW = 3;

    typedef enum logic {
        IDLE = 1'b0,
        EMIT = 1'b1
    } state_e;

    state_e          state_q, state_d;
    logic [W-1:0]    pending_q, pending_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic            last_q, last_d;
    logic            zero_drop_q, zero_drop_d;

    // Index of the set bit to emit next, chosen by ORDER.
    function automatic logic [IW-1:0] pick(input logic [W-1:0] v);
        logic [IW-1:0] idx;
        idx = '0;
        if (ORDER == 0) begin
            for (int i = W - 1; i >= 0; i--)
                if (v[i]) idx = IW'(i);
        end else begin
            for (int i = 0; i < W; i++)
                if (v[i]) idx = IW'(i);
        end
        return idx;
    endfunction

    function automatic logic single_bit(input logic [W-1:0] v);
        return (v != '0) && ((v & (v - W'(1))) == '0);
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            pending_q   <= '0;
            idx_q       <= '0;
            last_q      <= 1'b0;
            zero_drop_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            pending_q   <= pending_d;
            idx_q       <= idx_d;
            last_q      <= last_d;
            zero_drop_q <= zero_drop_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        pending_d   = pending_q;
        zero_drop_d = 1'b0;
        idx_d       = '0;
        last_d      = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    pending_d = in_bits;
                    if (in_bits != '0) state_d = EMIT;
                    else               zero_drop_d = 1'b1;
                end
            end
            EMIT: begin
                if (out_ready) begin
                    // Retire the index currently on out_idx.
                    pending_d = pending_q & ~(W'(1) << idx_q);
                    if (last_q) begin
                        state_d   = IDLE;
                        pending_d = '0;
                    end
                end
            end
            default: begin
                state_d   = IDLE;
                pending_d = '0;
            end
        endcase

        // Output index/last are precomputed so they come straight from flops.
        if (state_d == EMIT) begin
            idx_d  = pick(pending_d);
            last_d = single_bit(pending_d);
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == EMIT);
    assign out_idx   = idx_q;
    assign out_last  = last_q;
    assign zero_drop = zero_drop_q;

endmodule

// File: tb/tb_onehot_encoder_8_3.sv
// Directed scoreboard bench for onehot_encoder_8_3; runs ORDER=0 and ORDER=1
// instances side by side on shared stimulus.
module tb_onehot_encoder_8_3;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic [7:0] in_bits;
    logic       out_ready;

    logic       in_ready0, out_valid0, out_last0, zero_drop0;
    logic [2:0] out_idx0;
    logic       in_ready1, out_valid1, out_last1, zero_drop1;
    logic [2:0] out_idx1;

    int n_chk  = 0;
    int n_fail = 0;

    // Expected {last, idx} per instance.
    logic [3:0] q0[$];
    logic [3:0] q1[$];

    onehot_encoder_8_3 #(.ORDER(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_bits(in_bits),
        .in_ready(in_ready0), .out_valid(out_valid0), .out_idx(out_idx0),
        .out_last(out_last0), .out_ready(out_ready), .zero_drop(zero_drop0)
    );

    onehot_encoder_8_3 #(.ORDER(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_bits(in_bits),
        .in_ready(in_ready1), .out_valid(out_valid1), .out_idx(out_idx1),
        .out_last(out_last1), .out_ready(out_ready), .zero_drop(zero_drop1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference serialisation: ascending list for ORDER=0, descending for ORDER=1.
    task automatic push_vec(input logic [7:0] v);
        int list[$];
        for (int i = 0; i < 8; i++) if (v[i]) list.push_back(i);
        for (int k = 0; k < list.size(); k++) begin
            q0.push_back({k == list.size() - 1, 3'(list[k])});
            q1.push_back({k == list.size() - 1, 3'(list[list.size() - 1 - k])});
        end
    endtask

    // Monitor: outputs sampled on the falling edge, away from the active edge.
    always @(negedge clk) begin
        if (rst_n) begin
            if (out_valid0) begin
                if (q0.size() == 0) chk("unexpected_out0", {out_last0, out_idx0}, 16'hFFFF);
                else if (out_ready) chk("out0", {out_last0, out_idx0}, q0.pop_front());
                else chk("hold0", {out_last0, out_idx0}, q0[0]);
            end else begin
                chk("idle_out0", {out_last0, out_idx0}, 0);
            end
            if (out_valid1) begin
                if (q1.size() == 0) chk("unexpected_out1", {out_last1, out_idx1}, 16'hFFFF);
                else if (out_ready) chk("out1", {out_last1, out_idx1}, q1.pop_front());
                else chk("hold1", {out_last1, out_idx1}, q1[0]);
            end else begin
                chk("idle_out1", {out_last1, out_idx1}, 0);
            end
        end
    end

    // Caller is at posedge+1 with both instances idle; returns at posedge+1 after acceptance.
    task automatic send(input logic [7:0] v);
        in_valid = 1'b1;
        in_bits  = v;
        push_vec(v);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int k = 0;
        while (!(q0.size() == 0 && q1.size() == 0 && in_ready0 && in_ready1) && k < 100) begin
            @(posedge clk); #1;
            k++;
        end
        chk("drain_timeout", 16'(k < 100), 1);
        chk("in_ready_after_drain", {in_ready0, in_ready1}, 2'b11);
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b1;
        in_bits   = 8'h01;
        out_ready = 1'b1;
        #1;
        chk("reset_outs0", {in_ready0, out_valid0, out_idx0, out_last0, zero_drop0}, 7'b1000000);
        chk("reset_outs1", {in_ready1, out_valid1, out_idx1, out_last1, zero_drop1}, 7'b1000000);

        // Vector already presented when reset releases: taken on the first edge.
        push_vec(8'h01);
        #6 rst_n = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("first_edge_accept", {out_valid0, out_valid1}, 2'b11);
        drain();

        // Mixed vector at full throughput: exactly four transfer cycles.
        send(8'b1010_0110);
        repeat (4) begin @(posedge clk); #1; end
        chk("a6_done_q", 16'(q0.size() + q1.size()), 0);
        chk("a6_in_ready", {in_ready0, in_ready1}, 2'b11);

        // Predecoder round-trip: each one-hot vector gives a single last index.
        for (int i = 0; i < 8; i++) begin
            send(8'(1) << i);
            drain();
        end

        // All-zero vector is dropped with a single-cycle pulse.
        send(8'h00);
        chk("zero_drop_pulse", {zero_drop0, zero_drop1, out_valid0, out_valid1, in_ready0, in_ready1}, 6'b110011);
        @(posedge clk); #1;
        chk("zero_drop_clear", {zero_drop0, zero_drop1, out_valid0, out_valid1}, 4'b0000);

        // 8'hFF with backpressure; new input held valid throughout must be ignored.
        send(8'hFF);
        begin
            int c = 0;
            in_valid = 1'b1;
            while ((q0.size() != 0 || q1.size() != 0) && c < 100) begin
                out_ready = (c % 3 == 0);
                in_bits   = 8'($urandom) | 8'h01;
                chk("ff_in_ready_low", {in_ready0, in_ready1}, 2'b00);
                @(posedge clk); #1;
                c++;
            end
            in_valid  = 1'b0;
            out_ready = 1'b1;
            chk("ff_timeout", 16'(c < 100), 1);
        end
        drain();

        // Reset in the middle of emitting 8'hF0 discards the remainder.
        send(8'hF0);
        @(posedge clk); #1;
        chk("f0_first_done", 16'(q0.size()), 3);
        rst_n = 1'b0;
        #1;
        chk("async_rst0", {in_ready0, out_valid0, out_idx0, out_last0, zero_drop0}, 7'b1000000);
        chk("async_rst1", {in_ready1, out_valid1, out_idx1, out_last1, zero_drop1}, 7'b1000000);
        q0.delete();
        q1.delete();
        #7 rst_n = 1'b1;
        repeat (5) begin
            @(posedge clk); #1;
            chk("post_rst_quiet", {out_valid0, out_valid1, in_ready0, in_ready1}, 4'b0011);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/onehot_encoder_8_3.md
ONEHOT_ENCODER_8_3 -- requirements
Module: onehot_encoder_8_3

Interface
REQ-001 Parameter: ORDER, default 0, emit order (0 = lowest set bit first, 1 = highest set bit first).
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 in_valid  input  1  in_bits carries a vector to encode.
REQ-005 in_bits  input  8  request vector, bit i = line i asserted.
REQ-006 in_ready  output  1  block can accept a vector this cycle.
REQ-007 out_valid  output  1  out_idx holds a valid encoded index.
REQ-008 out_idx  output  3  binary index of the current set bit (0..7).
REQ-009 out_last  output  1  out_idx is the final set bit of the current vector.
REQ-010 out_ready  input  1  downstream accepts out_idx this cycle.
REQ-011 zero_drop  output  1  one-cycle pulse: an all-zero vector was accepted and discarded.

Function
REQ-012 The block SHALL be the inverse of the 3-to-8 predecoder: each accepted 8-bit vector is serialised into one 3-bit index per set bit.
REQ-013 FSM states SHALL be IDLE and EMIT only; in_ready SHALL equal (state == IDLE).
REQ-014 Input transfer SHALL occur on a rising edge with in_valid & in_ready; in_bits is loaded into an 8-bit pending register.
REQ-015 On an input transfer with in_bits != 0: state IDLE -> EMIT at that edge.
REQ-016 On an input transfer with in_bits == 0: state stays IDLE, zero_drop is high for exactly the following cycle, and no output is produced.
REQ-017 out_valid SHALL equal (state == EMIT); first out_valid is the cycle after the accepting edge (latency 1).
REQ-018 out_idx SHALL be the index of the lowest (ORDER=0) or highest (ORDER=1) set bit of pending, decoded from registered pending only.
REQ-019 out_last SHALL be high iff exactly one bit of pending is set while out_valid is high; low otherwise.
REQ-020 Output transfer SHALL occur on a rising edge with out_valid & out_ready; the emitted bit is cleared in pending at that edge.
REQ-021 On an output transfer with out_last high: state EMIT -> IDLE, pending becomes 0.
REQ-022 With out_ready low, out_valid, out_idx and out_last SHALL hold stable (no drop, no advance).
REQ-023 Throughput SHALL be one index per cycle while out_ready is high; a vector with k set bits occupies EMIT for exactly k transfer cycles.
REQ-024 in_valid and in_bits SHALL be ignored while in EMIT; a new vector is accepted no earlier than the cycle after the out_last transfer.
REQ-025 When out_valid is low, out_idx SHALL be 0 and out_last SHALL be 0.

Reset
REQ-026 rst_n low SHALL immediately, independent of clk, force state IDLE, pending 0, out_valid 0, out_idx 0, out_last 0, zero_drop 0, in_ready 1.
REQ-027 Reset asserted mid-EMIT SHALL discard remaining pending bits; no further output after rst_n deasserts until a new vector is accepted.
REQ-028 The first input transfer SHALL be possible on the first rising edge after rst_n deasserts.

Verification
REQ-029 ORDER=0, in_bits=8'b1010_0110, out_ready=1 -> out_idx 1,2,5,7 on four consecutive cycles, out_last high only with 7, then in_ready=1.
REQ-030 ORDER=1, same vector -> out_idx 7,5,2,1, out_last only with 1.
REQ-031 Predecoder round-trip: each of 8'b0000_0001 .. 8'b1000_0000 applied -> single output with out_idx 0..7 respectively, out_last=1.
REQ-032 in_bits=8'h00 accepted -> zero_drop pulses one cycle, out_valid stays 0, in_ready stays 1.
REQ-033 in_bits=8'hFF, out_ready toggled 1,0,0,1,... -> out_idx 0..7 each emitted once, held stable while out_ready=0, in_valid with new data ignored throughout.
REQ-034 in_bits=8'hF0 accepted, rst_n pulsed low after idx 4 transfer -> outputs 0 and in_ready=1 asynchronously, no idx 5..7 after release.
